// File: rtl/instruction_fetch_queue_pkg.sv
// ============================================================================
// Module   : instruction_fetch_queue_pkg
// Brief    : Shared types and defaults for the decoupled fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_queue_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int FETCH_DEPTH = 4;
    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [FETCH_XLEN-1:0] pc_plus4(input logic [FETCH_XLEN-1:0] pc);
        return pc + FETCH_XLEN'(4);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : DEPTH-entry FIFO of {pc, inst} with flush; head read from registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  fetch_entry_t                 i_push_data,
    input  logic                         i_pop,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    fetch_entry_t       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == c_cnt_w'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    // A full queue can still accept a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
// ============================================================================
// Module   : instruction_fetch_queue
// Brief    : Decoupled fetch stage: credit-limited imem requests, in-order
//            responses buffered with their PC, redirect flush. Optional
//            same-cycle response bypass when FETCH_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    // Entries are fetch_entry_t, so DATA_WIDTH must equal FETCH_XLEN.
    parameter int                    DATA_WIDTH = FETCH_XLEN,
    parameter int                    DEPTH      = FETCH_DEPTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_valid_o,
    output logic [DATA_WIDTH-1:0] imem_req_addr_o,
    input  logic                  imem_req_ready_i,
    input  logic                  imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
    output logic                  inst_valid_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    input  logic                  inst_ready_i
);

    localparam int c_cnt_w = $clog2(DEPTH+1);
    localparam int c_sum_w = c_cnt_w + 2;

    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic [DATA_WIDTH-1:0] r_rsp_pc;
    logic [c_cnt_w-1:0]    r_live;
    logic [c_cnt_w-1:0]    r_drop;

    logic [c_cnt_w-1:0]    w_count;
    fetch_entry_t          w_head;
    fetch_entry_t          w_rsp_entry;
    fetch_entry_t          w_out;
    logic [c_sum_w-1:0]    w_credit_sum;
    logic                  w_credit_ok;
    logic                  w_req_valid;
    logic                  w_req_fire;
    logic                  w_rsp_drop;
    logic                  w_rsp_keep;
    logic                  w_bypass;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic [DATA_WIDTH-1:0] w_redirect_pc;
    logic [c_cnt_w-1:0]    w_live_drop_sum;
    logic [c_cnt_w-1:0]    w_drop_redirect;
    logic                  w_unused;

    assign w_redirect_pc = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    assign w_unused      = &{1'b0, redirect_pc_i[1:0]};

    // Every queued entry and outstanding response holds one credit.
    assign w_credit_sum = c_sum_w'(w_count) + c_sum_w'(r_live) + c_sum_w'(r_drop);
    assign w_credit_ok  = (w_credit_sum < c_sum_w'(DEPTH));
    assign w_req_valid  = !rst && !redirect_i && w_credit_ok;
    assign w_req_fire   = w_req_valid && imem_req_ready_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp_drop = imem_rsp_valid_i && (r_drop != '0);
    assign w_rsp_keep = imem_rsp_valid_i && (r_drop == '0) && (r_live != '0) && !redirect_i;

    assign w_rsp_entry = '{pc: r_rsp_pc, inst: imem_rsp_data_i};

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_rsp_keep && (w_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fifo_push = w_rsp_keep && !(w_bypass && inst_ready_i);
    assign w_fifo_pop  = !redirect_i && inst_ready_i && (w_count != '0);

    assign w_live_drop_sum = r_live + r_drop;
    assign w_drop_redirect = (imem_rsp_valid_i && (w_live_drop_sum != '0))
                           ? w_live_drop_sum - c_cnt_w'(1) : w_live_drop_sum;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_i),
        .i_push      (w_fifo_push),
        .i_push_data (w_rsp_entry),
        .i_pop       (w_fifo_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_live     <= '0;
            r_drop     <= '0;
        end else if (redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_live     <= '0;
            r_drop     <= w_drop_redirect;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
            end
            if (w_rsp_keep) begin
                r_rsp_pc <= r_rsp_pc + DATA_WIDTH'(4);
            end
            case ({w_req_fire, w_rsp_keep})
                2'b10:   r_live <= r_live + c_cnt_w'(1);
                2'b01:   r_live <= r_live - c_cnt_w'(1);
                default: r_live <= r_live;
            endcase
            if (w_rsp_drop) begin
                r_drop <= r_drop - c_cnt_w'(1);
            end
        end
    end

    assign imem_req_valid_o = w_req_valid;
    assign imem_req_addr_o  = r_fetch_pc;

    assign w_out        = w_bypass ? w_rsp_entry : w_head;
    assign inst_valid_o = (w_count != '0) || w_bypass;
    assign inst_o       = w_out.inst;
    assign pc_o         = w_out.pc;
    assign pc_plus4_o   = pc_plus4(w_out.pc);

    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid_i |-> ((r_live != '0) || (r_drop != '0)));

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
// ============================================================================
// Module   : tb_instruction_fetch_queue
// Brief    : Self-checking bench: in-order memory model plus a queue-level
//            reference of the fetch stage, directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        inst_ready_i;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .pc_plus4_o       (pc_plus4_o),
        .inst_ready_i     (inst_ready_i)
    );

    // Outstanding memory requests, oldest first; kept=0 once a redirect orphans them.
    typedef struct { logic [31:0] addr; int due; bit kept; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    pend_t       pend[$];
    ent_t        q[$];
    logic [31:0] m_fetch_pc;
    int          cyc;
    int          last_due;
    int          n_checks;
    int          n_fail;

    bit          k_redirect;
    logic [31:0] k_redirect_pc;
    bit          k_mem_ready;
    bit          k_dec_ready;
    int          k_lat;

    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_inst_valid;
    logic [31:0] d_inst;
    logic [31:0] d_pc;
    logic [31:0] d_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit          rsp_v;
        bit          kept;
        bit          byp;
        bit          exp_rv;
        bit          exp_iv;
        bit          fire;
        logic [31:0] rdata;
        ent_t        head;
        pend_t       e;
        int          due;

        rsp_v = (pend.size() > 0) && (pend[0].due <= cyc);
        rdata = rsp_v ? mem_word(pend[0].addr) : $urandom;
        redirect_i       = k_redirect;
        redirect_pc_i    = k_redirect_pc;
        imem_req_ready_i = k_mem_ready;
        imem_rsp_valid_i = rsp_v;
        imem_rsp_data_i  = rdata;
        inst_ready_i     = k_dec_ready;

        kept   = rsp_v && pend[0].kept && !k_redirect;
        byp    = BYP && kept && (q.size() == 0);
        exp_rv = !k_redirect && ((q.size() + pend.size()) < DEPTH);
        exp_iv = (q.size() > 0) || byp;
        head   = '{pc: 32'h0, inst: 32'h0};
        if (q.size() > 0) head = q[0];
        else if (byp) head = '{pc: pend[0].addr, inst: rdata};

        @(negedge clk);
        d_req_valid  = imem_req_valid_o;
        d_req_addr   = imem_req_addr_o;
        d_inst_valid = inst_valid_o;
        d_inst       = inst_o;
        d_pc         = pc_o;
        d_pc4        = pc_plus4_o;
        check("req_valid", d_req_valid, exp_rv);
        if (exp_rv) check("req_addr", d_req_addr, m_fetch_pc);
        check("inst_valid", d_inst_valid, exp_iv);
        if (exp_iv) begin
            check("inst", d_inst, head.inst);
            check("pc", d_pc, head.pc);
            check("pc_plus4", d_pc4, head.pc + 32'd4);
        end

        @(posedge clk);
        fire = exp_rv && k_mem_ready;
        if (k_redirect) begin
            q.delete();
            foreach (pend[i]) pend[i].kept = 1'b0;
            if (rsp_v) void'(pend.pop_front());
            m_fetch_pc = {k_redirect_pc[31:2], 2'b00};
        end else begin
            if (exp_iv && k_dec_ready && (q.size() > 0)) void'(q.pop_front());
            if (rsp_v) begin
                e = pend.pop_front();
                if (kept && !(byp && k_dec_ready)) q.push_back('{pc: e.addr, inst: rdata});
            end
            if (fire) begin
                due = (cyc + k_lat > last_due + 1) ? cyc + k_lat : last_due + 1;
                pend.push_back('{addr: m_fetch_pc, due: due, kept: 1'b1});
                last_due = due;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        redirect_i       = 1'b0;
        redirect_pc_i    = 32'h0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        inst_ready_i     = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_req_valid", imem_req_valid_o, 1'b0);
        check("rst_req_addr", imem_req_addr_o, RPC);
        check("rst_inst_valid", inst_valid_o, 1'b0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_pc_plus4", pc_plus4_o, 32'h4);
        q.delete();
        pend.delete();
        m_fetch_pc = RPC;
        last_due   = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        last_due = -1;
        k_redirect = 1'b0;
        k_redirect_pc = 32'h0;
        k_mem_ready = 1'b1;
        k_dec_ready = 1'b1;
        k_lat = 1;
        rst = 1'b1;
        #1;
        do_reset();

        // Streaming: memory and decode always ready, 1-cycle latency.
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) check("a_first_addr", d_req_addr, 32'h0);
            if (i == 1) check("a_second_addr", d_req_addr, 32'h4);
            if (i == (BYP ? 1 : 2)) begin
                check("a_first_valid", d_inst_valid, 1'b1);
                check("a_first_pc", d_pc, 32'h0);
            end
            if (i == (BYP ? 2 : 3)) check("a_next_pc", d_pc, 32'h4);
        end

        // Decode stalled from reset: queue fills, requests stop, then drains in order.
        do_reset();
        k_dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("b_req_stalled", d_req_valid, 1'b0);
        check("b_head_valid", d_inst_valid, 1'b1);
        k_dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("b_drain_pc", d_pc, 32'(i * 4));
        end

        // Redirect with two or more 3-cycle responses still in flight.
        k_lat = 3;
        for (int i = 0; i < 6; i++) step();
        k_redirect = 1'b1;
        k_redirect_pc = 32'h100;
        step();
        k_redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (d_inst_valid) found = 1'b1;
        end
        check("c_found", found, 1'b1);
        check("c_pc", d_pc, 32'h100);

        // Redirect to an unaligned PC while a response lands in the same cycle.
        k_lat = 1;
        for (int i = 0; i < 8; i++) step();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if ((pend.size() > 0) && (pend[0].due <= cyc)) found = 1'b1;
            else step();
        end
        check("d_rsp_in_redirect", found, 1'b1);
        k_redirect = 1'b1;
        k_redirect_pc = 32'h203;
        step();
        k_redirect = 1'b0;
        step();
        check("d_addr", d_req_addr, 32'h200);
        step();
        check("d_valid_n2", d_inst_valid, BYP);
        step();
        check("d_valid_n3", d_inst_valid, 1'b1);
        check("d_pc_n3", d_pc, BYP ? 32'h204 : 32'h200);

        // Address wrap at the top of the address space.
        k_dec_ready = 1'b0;
        k_redirect = 1'b1;
        k_redirect_pc = 32'hFFFF_FFFC;
        step();
        k_redirect = 1'b0;
        step();
        check("e_addr_top", d_req_addr, 32'hFFFF_FFFC);
        step();
        check("e_addr_wrap", d_req_addr, 32'h0);
        found = d_inst_valid;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (d_inst_valid) found = 1'b1;
        end
        check("e_found", found, 1'b1);
        check("e_pc", d_pc, 32'hFFFF_FFFC);
        check("e_pc_plus4", d_pc4, 32'h0);
        k_dec_ready = 1'b1;

        // Random traffic with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            k_redirect  = ($urandom_range(0, 99) < 4);
            k_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : 32'($urandom);
            k_mem_ready = ($urandom_range(0, 99) < 75);
            k_dec_ready = ($urandom_range(0, 99) < 65);
            if (i % 200 == 0) k_lat = $urandom_range(1, 4);
            if (i == 1500) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
